// File: rtl/hood_pkg.sv
// Shared encodings, LED bit helpers and default timings for the range-hood
// mode controller and its timebase.
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_STANDBY   = 3'd1,
    MODE_RUN       = 3'd2,
    MODE_HURRICANE = 3'd3,
    MODE_CLEAN     = 3'd4,
    MODE_SHOW      = 3'd5
  } mode_e;

  localparam int DEF_TICK_DIV      = 32'd100_000_000;
  localparam int DEF_HURRICANE_SEC = 32'd60;
  localparam int DEF_CLEAN_SEC     = 32'd180;

  // LED vector layout, LSB first: standby, level 1..N, clean
  localparam int LED_STANDBY_BIT = 32'd0;

  function automatic int led_level_bit(input int lvl);
    return lvl;
  endfunction

  function automatic int led_clean_bit(input int num_levels);
    return num_levels + 32'd1;
  endfunction

endpackage

// File: rtl/hood_mode_ctrl_sec_tick.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick on the
// last count and sits at zero when disabled or cleared.
module sec_tick
  import hood_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  // Next prescaler value: held at zero when idle, wraps after the last count
  always_comb begin
    count_nxt_s = count_r;
    if (clr || !en) begin
      count_nxt_s = '0;
    end else if (count_r == LAST) begin
      count_nxt_s = '0;
    end else begin
      count_nxt_s = count_r + CW'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign tick = en && !clr && (count_r == LAST);

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: button edge detection, mode FSM, hurricane and
// self-clean countdowns, once-per-power-cycle hurricane lockout and LED drive.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int NUM_LEVELS    = 3,
  parameter int HURRICANE_SEC = DEF_HURRICANE_SEC,
  parameter int CLEAN_SEC     = DEF_CLEAN_SEC,
  parameter int TW            = 8,
  localparam int LW           = $clog2(NUM_LEVELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_on,
  input  logic                  menu_btn,
  input  logic [NUM_LEVELS-1:0] level_btn,
  input  logic                  clean_btn,
  input  logic                  show_time_btn,
  output logic [2:0]            mode,
  output logic [LW-1:0]         level,
  output logic [TW-1:0]         remaining_sec,
  output logic                  menu_armed,
  output logic                  hurricane_used,
  output logic [NUM_LEVELS+1:0] led
);

  localparam int            HI          = NUM_LEVELS - 1;
  localparam int            LEDW        = NUM_LEVELS + 2;
  localparam logic [LW-1:0] TOP_LEVEL   = LW'(NUM_LEVELS);
  localparam logic [LW-1:0] RET_LEVEL   = LW'(NUM_LEVELS - 1);
  localparam logic [TW-1:0] HURRICANE_T = TW'(HURRICANE_SEC);
  localparam logic [TW-1:0] CLEAN_T     = TW'(CLEAN_SEC);

  mode_e           mode_r, mode_nxt_s;
  logic [LW-1:0]   level_r, level_nxt_s;
  logic [TW-1:0]   remain_r, remain_nxt_s;
  logic            armed_r, armed_nxt_s;
  logic            used_r, used_nxt_s;
  logic [LEDW-1:0] led_r, led_nxt_s;

  logic                  menu_q_r, clean_q_r, show_q_r;
  logic [NUM_LEVELS-1:0] level_q_r;
  logic                  menu_e_s, clean_e_s, show_e_s;
  logic [NUM_LEVELS-1:0] lvl_e_s, run_e_s;
  logic [LW-1:0]         sel_s, run_sel_s;
  logic                  timed_s, enter_timed_s, tick_s, expire_s;

  // Level number (index+1) of the lowest set bit, 0 when none is set
  function automatic logic [LW-1:0] lowest_level(input logic [NUM_LEVELS-1:0] v);
    logic [LW-1:0] sel;
    sel = '0;
    for (int k = NUM_LEVELS - 1; k >= 0; k--) begin
      sel = v[k] ? LW'(k + 1) : sel;
    end
    return sel;
  endfunction

  assign menu_e_s  = menu_btn & ~menu_q_r;
  assign clean_e_s = clean_btn & ~clean_q_r;
  assign show_e_s  = show_time_btn & ~show_q_r;
  assign lvl_e_s   = level_btn & ~level_q_r;

  // In RUN the hurricane button has no effect, so mask it before selection
  always_comb begin
    run_e_s     = lvl_e_s;
    run_e_s[HI] = 1'b0;
  end

  assign sel_s     = lowest_level(lvl_e_s);
  assign run_sel_s = lowest_level(run_e_s);

  assign timed_s       = (mode_r == MODE_HURRICANE) || (mode_r == MODE_CLEAN);
  assign enter_timed_s = ((mode_nxt_s == MODE_HURRICANE) || (mode_nxt_s == MODE_CLEAN)) && !timed_s;
  assign expire_s      = tick_s && (remain_r == TW'(1));

  sec_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_timed_s),
    .en   (timed_s),
    .tick (tick_s)
  );

  // Mode FSM next-state and countdown logic
  always_comb begin
    mode_nxt_s   = mode_r;
    level_nxt_s  = level_r;
    remain_nxt_s = remain_r;
    armed_nxt_s  = armed_r;
    used_nxt_s   = used_r;
    if (!power_on) begin
      mode_nxt_s   = MODE_OFF;
      level_nxt_s  = '0;
      remain_nxt_s = '0;
      armed_nxt_s  = 1'b0;
      used_nxt_s   = 1'b0;
    end else begin
      case (mode_r)
        MODE_OFF: begin
          mode_nxt_s   = MODE_STANDBY;
          level_nxt_s  = '0;
          remain_nxt_s = '0;
          armed_nxt_s  = 1'b0;
        end
        MODE_STANDBY: begin
          // A menu edge only toggles the arm, even alongside a selection
          if (menu_e_s) begin
            armed_nxt_s = ~armed_r;
          end else if (armed_r && (sel_s != '0)) begin
            if (sel_s != TOP_LEVEL) begin
              mode_nxt_s  = MODE_RUN;
              level_nxt_s = sel_s;
              armed_nxt_s = 1'b0;
            end else if (!used_r) begin
              mode_nxt_s   = MODE_HURRICANE;
              level_nxt_s  = TOP_LEVEL;
              remain_nxt_s = HURRICANE_T;
              used_nxt_s   = 1'b1;
              armed_nxt_s  = 1'b0;
            end else begin
              armed_nxt_s = 1'b1;
            end
          end else if (armed_r && clean_e_s) begin
            mode_nxt_s   = MODE_CLEAN;
            level_nxt_s  = '0;
            remain_nxt_s = CLEAN_T;
            armed_nxt_s  = 1'b0;
          end else if (armed_r && show_e_s) begin
            mode_nxt_s  = MODE_SHOW;
            armed_nxt_s = 1'b0;
          end else begin
            armed_nxt_s = armed_r;
          end
        end
        MODE_RUN: begin
          if (menu_e_s) begin
            mode_nxt_s  = MODE_STANDBY;
            level_nxt_s = '0;
            armed_nxt_s = 1'b0;
          end else if (run_sel_s != '0) begin
            level_nxt_s = run_sel_s;
          end else begin
            level_nxt_s = level_r;
          end
        end
        MODE_HURRICANE: begin
          armed_nxt_s = armed_r | menu_e_s;
          if (tick_s) begin
            remain_nxt_s = remain_r - TW'(1);
          end else begin
            remain_nxt_s = remain_r;
          end
          if (expire_s) begin
            armed_nxt_s  = 1'b0;
            remain_nxt_s = '0;
            if (armed_r) begin
              mode_nxt_s  = MODE_RUN;
              level_nxt_s = RET_LEVEL;
            end else begin
              mode_nxt_s  = MODE_STANDBY;
              level_nxt_s = '0;
            end
          end else begin
            mode_nxt_s = MODE_HURRICANE;
          end
        end
        MODE_CLEAN: begin
          if (expire_s) begin
            mode_nxt_s   = MODE_STANDBY;
            remain_nxt_s = '0;
          end else if (tick_s) begin
            remain_nxt_s = remain_r - TW'(1);
          end else begin
            remain_nxt_s = remain_r;
          end
        end
        MODE_SHOW: begin
          if (menu_e_s) begin
            mode_nxt_s = MODE_STANDBY;
          end else begin
            mode_nxt_s = MODE_SHOW;
          end
        end
        default: begin
          mode_nxt_s   = MODE_OFF;
          level_nxt_s  = '0;
          remain_nxt_s = '0;
          armed_nxt_s  = 1'b0;
          used_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // LED pattern derived from the next state so it registers alongside mode
  always_comb begin
    led_nxt_s = '0;
    case (mode_nxt_s)
      MODE_STANDBY, MODE_SHOW:   led_nxt_s = LEDW'(1) << LED_STANDBY_BIT;
      MODE_RUN, MODE_HURRICANE:  led_nxt_s = LEDW'(1) << led_level_bit(int'(level_nxt_s));
      MODE_CLEAN:                led_nxt_s = LEDW'(1) << led_clean_bit(NUM_LEVELS);
      default:                   led_nxt_s = '0;
    endcase
  end

  // State, output and button-history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= MODE_OFF;
      level_r   <= '0;
      remain_r  <= '0;
      armed_r   <= 1'b0;
      used_r    <= 1'b0;
      led_r     <= '0;
      menu_q_r  <= 1'b0;
      clean_q_r <= 1'b0;
      show_q_r  <= 1'b0;
      level_q_r <= '0;
    end else begin
      mode_r    <= mode_nxt_s;
      level_r   <= level_nxt_s;
      remain_r  <= remain_nxt_s;
      armed_r   <= armed_nxt_s;
      used_r    <= used_nxt_s;
      led_r     <= led_nxt_s;
      menu_q_r  <= menu_btn;
      clean_q_r <= clean_btn;
      show_q_r  <= show_time_btn;
      level_q_r <= level_btn;
    end
  end

  assign mode           = mode_r;
  assign level          = level_r;
  assign remaining_sec  = remain_r;
  assign menu_armed     = armed_r;
  assign hurricane_used = used_r;
  assign led            = led_r;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Scoreboard bench for hood_mode_ctrl (TICK_DIV=4, 3 levels, 3 s hurricane,
// 5 s clean); observed word is {mode, level, remaining, armed, used, led}.
module tb_hood_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       power_on;
  logic       menu_btn;
  logic [2:0] level_btn;
  logic       clean_btn;
  logic       show_time_btn;
  logic [2:0] mode;
  logic [1:0] level;
  logic [7:0] remaining_sec;
  logic       menu_armed;
  logic       hurricane_used;
  logic [4:0] led;
  logic [19:0] obs;

  typedef struct {
    logic [19:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  hood_mode_ctrl #(
    .TICK_DIV      (4),
    .NUM_LEVELS    (3),
    .HURRICANE_SEC (3),
    .CLEAN_SEC     (5),
    .TW            (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .power_on       (power_on),
    .menu_btn       (menu_btn),
    .level_btn      (level_btn),
    .clean_btn      (clean_btn),
    .show_time_btn  (show_time_btn),
    .mode           (mode),
    .level          (level),
    .remaining_sec  (remaining_sec),
    .menu_armed     (menu_armed),
    .hurricane_used (hurricane_used),
    .led            (led)
  );

  always #5 clk = ~clk;

  assign obs = {mode, level, remaining_sec, menu_armed, hurricane_used, led};

  function automatic logic [19:0] pk(input logic [2:0] m, input logic [1:0] lv,
                                     input logic [7:0] r, input logic a,
                                     input logic u, input logic [4:0] l);
    return {m, lv, r, a, u, l};
  endfunction

  task automatic sb_push(input logic [19:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic m, input logic [2:0] lv, input logic c, input logic s);
    menu_btn      = m;
    level_btn     = lv;
    clean_btn     = c;
    show_time_btn = s;
  endtask

  // One idle cycle, then the buttons high for one cycle, then released
  task automatic pulse(input logic m, input logic [2:0] lv, input logic c, input logic s);
    set_btn(1'b0, 3'b000, 1'b0, 1'b0);
    cyc();
    set_btn(m, lv, c, s);
    cyc();
    set_btn(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    exp_t e;
    cyc();
    cyc();
    sb_push(20'h0, "reset_state");
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    rst = 1'b1;
    sb_push(20'h0, "off_after_reset");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
  endtask

  task automatic test_standby_run();
    exp_t e;
    logic [2:0]  lv[5]   = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b000};
    logic        mb[5]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        cs[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [19:0] ex[5];
    string       tg[5]   = '{"menu_arm", "run_level2", "run_ignores_hurr_clean_show",
                             "run_level1", "run_to_standby"};
    ex[0] = pk(3'd1, 2'd0, 8'd0, 1'b1, 1'b0, 5'b00001);
    ex[1] = pk(3'd2, 2'd2, 8'd0, 1'b0, 1'b0, 5'b00100);
    ex[2] = pk(3'd2, 2'd2, 8'd0, 1'b0, 1'b0, 5'b00100);
    ex[3] = pk(3'd2, 2'd1, 8'd0, 1'b0, 1'b0, 5'b00010);
    ex[4] = pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001);
    power_on = 1'b1;
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "standby_entry");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    for (int i = 0; i < 5; i++) begin
      sb_push(ex[i], tg[i]);
      pulse(mb[i], lv[i], cs[i], cs[i]);
      e = sb.pop_front(); n_asserts++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_show();
    exp_t e;
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd5, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "show_entry");
    pulse(1'b0, 3'b000, 1'b0, 1'b1);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "show_exit");
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
  endtask

  task automatic test_hurricane();
    exp_t e;
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd3, 2'd3, 8'd3, 1'b0, 1'b1, 5'b01000), "hurr_entry");
    pulse(1'b0, 3'b100, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    for (int i = 1; i <= 12; i++) begin
      if (i < 12) sb_push(pk(3'd3, 2'd3, 8'(3 - i / 4), 1'b0, 1'b1, 5'b01000), "hurr_count");
      else        sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b1, 5'b00001), "hurr_expire");
      cyc();
      e = sb.pop_front(); n_asserts++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h (cycle %0d)", e.tag, obs, e.v, i); end
    end
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b1, 1'b1, 5'b00001), "rearm_after_hurr");
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b1, 1'b1, 5'b00001), "hurr_lockout");
    pulse(1'b0, 3'b100, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
  endtask

  task automatic test_return_level();
    exp_t e;
    power_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_push(20'h0, "power_off");
      cyc();
      e = sb.pop_front(); n_asserts++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    end
    power_on = 1'b1;
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "power_on_fresh");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd3, 2'd3, 8'd3, 1'b0, 1'b1, 5'b01000), "hurr_reentry");
    pulse(1'b0, 3'b100, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    repeat (3) cyc();
    sb_push(pk(3'd3, 2'd3, 8'd2, 1'b1, 1'b1, 5'b01000), "hurr_menu_at_2");
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    repeat (5) cyc();
    sb_push(pk(3'd3, 2'd3, 8'd1, 1'b1, 1'b1, 5'b01000), "hurr_last_sec");
    sb_push(pk(3'd2, 2'd2, 8'd0, 1'b0, 1'b1, 5'b00100), "return_to_level");
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = sb.pop_front(); n_asserts++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_clean();
    exp_t e;
    logic b;
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd4, 2'd0, 8'd5, 1'b0, 1'b1, 5'b10000), "clean_entry");
    pulse(1'b0, 3'b000, 1'b1, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    for (int i = 1; i <= 20; i++) begin
      b = 1'(i % 2);
      set_btn(b, {b, b, b}, b, b);
      if (i < 20) sb_push(pk(3'd4, 2'd0, 8'(5 - i / 4), 1'b0, 1'b1, 5'b10000), "clean_count");
      else        sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b1, 5'b00001), "clean_expire");
      cyc();
      e = sb.pop_front(); n_asserts++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h (cycle %0d)", e.tag, obs, e.v, i); end
    end
    set_btn(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_power_off_clean();
    exp_t e;
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd4, 2'd0, 8'd5, 1'b0, 1'b1, 5'b10000), "clean_entry2");
    pulse(1'b0, 3'b000, 1'b1, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    repeat (11) cyc();
    sb_push(pk(3'd4, 2'd0, 8'd2, 1'b0, 1'b1, 5'b10000), "clean_at_2");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    power_on = 1'b0;
    sb_push(20'h0, "clean_power_off");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    power_on = 1'b1;
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "standby_after_off");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd4, 2'd0, 8'd5, 1'b0, 1'b0, 5'b10000), "clean_fresh");
    pulse(1'b0, 3'b000, 1'b1, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    repeat (2) cyc();
    sb_push(pk(3'd4, 2'd0, 8'd5, 1'b0, 1'b0, 5'b10000), "clean_fresh_hold");
    sb_push(pk(3'd4, 2'd0, 8'd4, 1'b0, 1'b0, 5'b10000), "clean_fresh_tick");
    for (int i = 0; i < 2; i++) begin
      cyc();
      e = sb.pop_front(); n_asserts++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    power_on = 1'b0;
    cyc();
    power_on = 1'b1;
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "same_cycle_base");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b1, 1'b0, 5'b00001), "menu_beats_select");
    pulse(1'b1, 3'b001, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    sb_push(pk(3'd2, 2'd1, 8'd0, 1'b0, 1'b0, 5'b00010), "run_from_armed");
    pulse(1'b0, 3'b001, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "run_menu_beats_level");
    pulse(1'b1, 3'b001, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    pulse(1'b1, 3'b000, 1'b0, 1'b0);
    sb_push(pk(3'd3, 2'd3, 8'd3, 1'b0, 1'b1, 5'b01000), "hurr_before_reset");
    pulse(1'b0, 3'b100, 1'b0, 1'b0);
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    repeat (2) cyc();
    #2;
    rst = 1'b0;
    #1;
    sb_push(20'h0, "async_reset");
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
    cyc();
    rst = 1'b1;
    sb_push(pk(3'd1, 2'd0, 8'd0, 1'b0, 1'b0, 5'b00001), "standby_after_reset");
    cyc();
    e = sb.pop_front(); n_asserts++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %05h expected %05h", e.tag, obs, e.v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got unfinished run expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    power_on = 1'b0;
    set_btn(1'b0, 3'b000, 1'b0, 1'b0);
    test_reset();
    test_standby_run();
    test_show();
    test_hurricane();
    test_return_level();
    test_clean();
    test_power_off_clean();
    test_same_cycle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
